// File: rtl/ahb_read_ctrl.sv
// ahb_read_ctrl
// AHB-Lite slave-side sequencer for an 8-bit read register datapath.
// Captures the address phase, decodes the register select, inserts
// WAIT_STATES hreadyout-low cycles per legal read and strobes the datapath
// so hrdata is loaded just before the final data-phase cycle. Illegal
// transfers get the two-cycle ERROR response and bump a saturating counter.
//
// Ports:
//   hclk, hreset_n   clock, asynchronous active-low reset
//   hsel, htrans     slave select, transfer type (NONSEQ=2, SEQ=3)
//   hwrite, haddr    direction (1 = write), byte address
//   hsize, hready    transfer size (only byte legal), bus-level HREADY
//   hreadyout, hresp slave ready, response (1 = ERROR)
//   read_select      registered register index to the datapath
//   rd_strobe        one-cycle datapath load enable
//   busy             high whenever a data phase is in progress
//   err_count        saturating count of ERROR responses issued
module ahb_read_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [1:0]        read_select,
  output logic              rd_strobe,
  output logic              busy,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic [1:0] sel_nxt;
  logic [7:0] err_nxt;
  logic       accept;
  logic       legal;

  assign accept = hsel & htrans[1] & hready;
  assign legal  = ~hwrite & (hsize == 3'd0) & (haddr[ADDR_W-1:2] == '0);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      read_select <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      read_select <= sel_nxt;
      err_count   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    sel_nxt      = read_select;
    err_nxt      = err_count;
    case (state)
      // Every state with hreadyout high is a legal address-phase slot,
      // which gives back-to-back pipelining out of DONE and ERR2.
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          if (legal) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
            sel_nxt      = haddr[1:0];
          end else begin
            state_nxt = S_ERR1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = S_DONE;
      end
      S_ERR1: begin
        if (err_count != '1) err_nxt = err_count + 8'd1;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode only the state/counter flops, never the bus inputs.
  assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign rd_strobe = (state == S_WAIT) && (wait_cnt == 4'd1);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ahb_read_ctrl.sv
module tb_ahb_read_ctrl;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       hsel;
  logic [1:0] htrans;
  logic       hwrite;
  logic [7:0] haddr;
  logic [2:0] hsize;
  logic       hready;

  logic       hro  [2];
  logic       hrs  [2];
  logic [1:0] rsel [2];
  logic       strb [2];
  logic       bsy  [2];
  logic [7:0] ecnt [2];

  always #5 hclk = ~hclk;

  ahb_read_ctrl #(.WAIT_STATES(1), .ADDR_W(8)) u_dut_ws1 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hready(hready),
    .hreadyout(hro[0]), .hresp(hrs[0]), .read_select(rsel[0]),
    .rd_strobe(strb[0]), .busy(bsy[0]), .err_count(ecnt[0])
  );

  ahb_read_ctrl #(.WAIT_STATES(4), .ADDR_W(8)) u_dut_ws4 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hready(hready),
    .hreadyout(hro[1]), .hresp(hrs[1]), .read_select(rsel[1]),
    .rd_strobe(strb[1]), .busy(bsy[1]), .err_count(ecnt[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a data phase is described by its kind and the
  // position (cycle index) within it; legal reads last ws+1 cycles,
  // errors last 2.
  int unsigned ws [2] = '{1, 4};
  bit          m_act [2];
  bit          m_isr [2];
  int unsigned m_pos [2];
  int unsigned m_sel [2];
  int unsigned m_cnt [2];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned phase_len(input int i);
    return m_isr[i] ? ws[i] + 1 : 2;
  endfunction

  function automatic bit m_last(input int i);
    return m_pos[i] == phase_len(i) - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_isr[i] = 0; m_pos[i] = 0; m_sel[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_update();
    bit acc, legal;
    if (!hreset_n) return;
    acc   = hsel && htrans[1] && hready;
    legal = !hwrite && hsize == 0 && haddr < 4;
    for (int i = 0; i < 2; i++) begin
      if (m_act[i] && !m_isr[i] && m_pos[i] == 0 && m_cnt[i] < 255) m_cnt[i]++;
      if (!m_act[i] || m_last(i)) begin
        m_act[i] = acc;
        m_isr[i] = legal;
        m_pos[i] = 0;
        if (acc && legal) m_sel[i] = haddr % 4;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = $sformatf("ws%0d_", ws[i]);
      chk({p, "hreadyout"}, hro[i], (!m_act[i] || m_last(i)) ? 1 : 0);
      chk({p, "hresp"}, hrs[i], (m_act[i] && !m_isr[i]) ? 1 : 0);
      chk({p, "read_select"}, rsel[i], m_sel[i]);
      chk({p, "rd_strobe"}, strb[i], (m_act[i] && m_isr[i] && m_pos[i] == ws[i] - 1) ? 1 : 0);
      chk({p, "busy"}, bsy[i], m_act[i] ? 1 : 0);
      chk({p, "err_count"}, ecnt[i], m_cnt[i]);
    end
  endtask

  task automatic bus(input bit s, input logic [1:0] t, input bit w,
                     input logic [7:0] a, input logic [2:0] sz, input bit rdy);
    hsel = s; htrans = t; hwrite = w; haddr = a; hsize = sz; hready = rdy;
  endtask

  task automatic step();
    @(posedge hclk);
    model_update();
    @(negedge hclk);
    check_all();
  endtask

  task automatic idle(input int n);
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    for (int k = 0; k < n; k++) step();
  endtask

  // Called at a negedge; asserts reset asynchronously, checks, releases.
  task automatic pulse_reset();
    #1 hreset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge hclk);
    check_all();
    hreset_n = 1'b1;
  endtask

  int strobes;
  int unsigned sel_seq [$];

  initial begin
    hreset_n = 1'b0;
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    model_reset();
    @(negedge hclk);
    check_all();
    hreset_n = 1'b1;

    // single read of 0x02
    bus(1, 2'd2, 0, 8'h02, 3'd0, 1);
    step();
    chk("t1_c1_hreadyout", hro[0], 0);
    chk("t1_c1_strobe", strb[0], 1);
    chk("t1_c1_select", rsel[0], 2);
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    step();
    chk("t1_c2_hreadyout", hro[0], 1);
    chk("t1_c2_hresp", hrs[0], 0);
    idle(6);

    // back-to-back reads 0, 1, 3 on the single-wait-state instance
    strobes = 0;
    sel_seq.delete();
    bus(1, 2'd2, 0, 8'h00, 3'd0, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (strb[0]) begin strobes++; sel_seq.push_back(rsel[0]); end
      if (k == 0 || k == 1) bus(1, 2'd2, 0, 8'h01, 3'd0, 1);
      if (k == 2 || k == 3) bus(1, 2'd2, 0, 8'h03, 3'd0, 1);
      if (k == 4) bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
      if (k == 1 || k == 3) chk("b2b_done_busy", bsy[0], 1);
    end
    chk("b2b_strobes", strobes, 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b_sel%0d", k), (k < sel_seq.size()) ? sel_seq[k] : 99,
          (k == 2) ? 3 : k);
    idle(6);

    // write -> two-cycle ERROR
    bus(1, 2'd2, 1, 8'h01, 3'd0, 1);
    step();
    chk("wr_c1_hresp", hrs[0], 1);
    chk("wr_c1_hreadyout", hro[0], 0);
    chk("wr_c1_strobe", strb[0], 0);
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    step();
    chk("wr_c2_hresp", hrs[0], 1);
    chk("wr_c2_hreadyout", hro[0], 1);
    chk("wr_errcnt", ecnt[0], 1);
    idle(6);

    // out-of-range address and wide size from a fresh reset
    pulse_reset();
    idle(2);
    bus(1, 2'd2, 0, 8'h04, 3'd0, 1);
    step();
    bus(1, 2'd3, 0, 8'h01, 3'd1, 1);
    step();
    step();
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    step();
    chk("illegal_errcnt", ecnt[0], 2);
    idle(3);

    // 300 more errors, pipelined through ERR2
    bus(1, 2'd2, 1, 8'h00, 3'd0, 1);
    for (int k = 0; k < 600; k++) step();
    idle(4);
    chk("sat_errcnt_ws1", ecnt[0], 255);
    chk("sat_errcnt_ws4", ecnt[1], 255);

    // BUSY with hsel, then NONSEQ without hsel
    bus(1, 2'd1, 0, 8'h00, 3'd0, 1);
    step();
    chk("busy_tr_hreadyout", hro[0], 1);
    chk("busy_tr_busy", bsy[0], 0);
    bus(0, 2'd2, 0, 8'h00, 3'd0, 1);
    step();
    chk("nosel_hresp", hrs[0], 0);
    chk("nosel_busy", bsy[1], 0);
    idle(2);

    // reset in the middle of a 4-wait-state read (counter = 2)
    bus(1, 2'd2, 0, 8'h03, 3'd0, 1);
    step();
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    step();
    step();
    chk("pre_rst_busy", bsy[1], 1);
    pulse_reset();
    chk("rst_hreadyout", hro[1], 1);
    chk("rst_busy", bsy[1], 0);
    chk("rst_strobe", strb[1], 0);
    chk("rst_errcnt", ecnt[1], 0);
    idle(3);
    bus(1, 2'd2, 0, 8'h01, 3'd0, 1);
    step();
    bus(0, 2'd0, 0, 8'h00, 3'd0, 1);
    for (int k = 0; k < 5; k++) step();
    chk("post_rst_select", rsel[1], 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
      end else begin
        hsel   = ($urandom_range(0, 9) < 8);
        htrans = 2'($urandom_range(0, 3));
        hwrite = ($urandom_range(0, 99) < 15);
        haddr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'b0, 2'($urandom)};
        hsize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        hready = ($urandom_range(0, 9) != 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_read_ctrl.md
Name: ahb_read_ctrl

Overview:
- AHB-Lite slave-side sequencer for the 8-bit read register datapath (err_status, payload_0, payload_1, data_size).
- Captures the address phase, decodes the register select, and inserts programmable wait states.
- Strobes the datapath so that hrdata is registered in time for the final data-phase cycle.
- Generates the two-cycle AHB ERROR response for illegal transfers and keeps a saturating error counter.

Parameters:
- WAIT_STATES, 1, number of hreadyout-low cycles per legal read; legal range 1..15.
- ADDR_W, 8, width of haddr.

Ports:
- hclk  input  1  AHB clock.
- hreset_n  input  1  reset; asynchronous, active-low.
- hsel  input  1  slave select from the decoder.
- htrans  input  2  AHB transfer type; NONSEQ=2, SEQ=3.
- hwrite  input  1  transfer direction; 1 = write.
- haddr  input  ADDR_W  byte address.
- hsize  input  3  transfer size; only 0 (byte) is legal.
- hready  input  1  bus-level HREADY; qualifies the address phase.
- hreadyout  output  1  slave ready to the bus.
- hresp  output  1  0 = OKAY, 1 = ERROR.
- read_select  output  2  register index to the datapath; registered.
- rd_strobe  output  1  one-cycle datapath load enable.
- busy  output  1  high while a data phase is in progress (any state other than IDLE).
- err_count  output  8  saturating count of ERROR responses issued.

Behaviour:
- Reset (async, hreset_n low):
  - state = IDLE, hreadyout = 1, hresp = 0.
  - read_select = 0, rd_strobe = 0, err_count = 0, internal wait counter = 0.
  - Assertion mid-transfer aborts immediately; no strobe or error is issued after release.
- Accept condition: hsel & htrans[1] & hready at a rising edge.
  - Allowed in IDLE and in any final data-phase cycle (hreadyout = 1), which gives back-to-back pipelining.
  - hsel = 0 or htrans IDLE/BUSY: no accept; hreadyout = 1, hresp = 0 (zero-wait OKAY).
- Legal transfer: hwrite = 0, hsize = 0, haddr[ADDR_W-1:2] = 0.
  - Any other accepted transfer is illegal.
- Legal read, on accept:
  - read_select <= haddr[1:0].
  - Wait counter <= WAIT_STATES.
  - state -> WAIT.
- WAIT state:
  - hreadyout = 0, hresp = 0.
  - Counter decrements each cycle.
  - rd_strobe = 1 only in the cycle where the counter equals 1; the datapath loads hrdata at the end of that cycle.
  - When the counter reaches 0: state -> DONE.
- DONE state:
  - hreadyout = 1, hresp = 0; hrdata is valid.
  - Next state: accept (WAIT or ERR1) or IDLE.
- Illegal transfer, on accept: state -> ERR1.
  - No rd_strobe is issued; read_select holds its previous value.
- ERR1: hreadyout = 0, hresp = 1; err_count increments, saturating at 255. Next state ERR2.
- ERR2: hreadyout = 1, hresp = 1. A new accept in this cycle is honoured; otherwise next state IDLE.
- Total data-phase length:
  - Legal read: WAIT_STATES + 1 cycles.
  - Error: exactly 2 cycles.
- Inputs are sampled only at accept; changes to haddr or hwrite during the data phase are ignored.
- hready low while in IDLE or DONE blocks accept; state holds (DONE falls to IDLE).
- rd_strobe is never asserted in ERR1, ERR2, IDLE or DONE.
- Outputs are registered from state.

Test Plan:
- Reset, then a NONSEQ read of haddr = 0x02 with WAIT_STATES = 1:
  - cycle 1: hreadyout = 0, rd_strobe = 1, read_select = 2.
  - cycle 2: hreadyout = 1, hresp = 0.
- Back-to-back reads of 0x00, 0x01, 0x03 (htrans NONSEQ each accepted in DONE):
  - read_select sequence 0, 1, 3.
  - Exactly three rd_strobe pulses; no idle cycle between transfers.
- Write to 0x01:
  - hresp = 1 for two cycles, hreadyout pattern 0 then 1.
  - No rd_strobe; err_count = 1.
- Read of 0x04 (out of range), then read with hsize = 1:
  - Each produces a two-cycle ERROR; err_count = 2.
  - Issuing 300 further errors leaves err_count = 255.
- htrans = BUSY with hsel = 1, then hsel = 0 with NONSEQ:
  - hreadyout stays 1, hresp = 0, no strobe, busy = 0.
- Assert hreset_n low during WAIT (WAIT_STATES = 4, counter = 2), then release:
  - hreadyout = 1, busy = 0, rd_strobe = 0.
  - err_count = 0; the next legal read behaves normally.
